// File: rtl/flow_addr_pkg.sv
// Shared constants and types for the flow feature-address free list.
// Pair index k maps to forward address k and reverse address k + NUM_FLOWS.
package flow_addr_pkg;

  localparam int unsigned FeaAddrW    = 12;
  localparam int unsigned DefNumFlows = 2048;
  localparam int unsigned MaxIdxW     = $clog2(DefNumFlows);

  typedef logic [MaxIdxW-1:0] pair_idx_t;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/flow_addr_free_list_if.sv
// Release and allocation signals of the flow feature-address free list.
// The slave modport is the free list itself; master is the surrounding logic.
interface flow_addr_free_list_if
  import flow_addr_pkg::*;
#(
  parameter int unsigned NUM_FLOWS  = DefNumFlows,
  parameter int unsigned FEA_ADDR_W = FeaAddrW
);

  localparam int unsigned CntW = $clog2(NUM_FLOWS) + 1;

  logic                  rel_v;
  logic [FEA_ADDR_W-1:0] rel_fea_addr;
  logic [FEA_ADDR_W-1:0] rel_r_fea_addr;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [FEA_ADDR_W-1:0] alloc_fea_addr;
  logic [FEA_ADDR_W-1:0] alloc_r_fea_addr;
  logic                  init_done;
  logic [CntW-1:0]       free_count;
  logic                  err_overflow;
  logic                  err_mismatch;

  modport master (
    output rel_v, rel_fea_addr, rel_r_fea_addr, alloc_ready,
    input  alloc_valid, alloc_fea_addr, alloc_r_fea_addr, init_done, free_count,
    input  err_overflow, err_mismatch
  );

  modport slave (
    input  rel_v, rel_fea_addr, rel_r_fea_addr, alloc_ready,
    output alloc_valid, alloc_fea_addr, alloc_r_fea_addr, init_done, free_count,
    output err_overflow, err_mismatch
  );

endinterface

// File: rtl/flow_addr_pool_ram.sv
// Pair-index storage: register array, one synchronous write port, one async read port.
// Contents are not reset; the owner initialises them.
module flow_addr_pool_ram #(
  parameter int unsigned Depth = 2048,
  parameter int unsigned Width = 11,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/flow_addr_free_list.sv
// Free-pair allocator: a circular FIFO of pair indices filled at reset, drained by the
// flow tracker through a one-entry output register and refilled by released pairs.
module flow_addr_free_list
  import flow_addr_pkg::*;
#(
  parameter int unsigned NUM_FLOWS  = DefNumFlows,
  parameter int unsigned FEA_ADDR_W = FeaAddrW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  flow_addr_free_list_if.slave bus
);

  localparam int unsigned      IdxW      = $clog2(NUM_FLOWS);
  localparam int unsigned      PtrW      = IdxW + 1;
  localparam logic [PtrW-1:0]  PoolSize  = PtrW'(NUM_FLOWS);
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(NUM_FLOWS - 1);
  localparam logic [FEA_ADDR_W:0] RevOffset = (FEA_ADDR_W + 1)'(NUM_FLOWS);

  state_e          state_q;
  logic [IdxW-1:0] init_cnt_q;
  logic            init_done_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0] free_count_q;
  logic            out_full_q;
  logic [IdxW-1:0] out_idx_q;
  logic            err_overflow_q, err_mismatch_q;

  logic            in_run, fifo_empty, fifo_full, pool_full, pair_ok;
  logic            rel_accept, alloc_fire, pop, wr_en;
  logic [IdxW-1:0] wr_data, rd_data;

  always_comb begin
    in_run     = (state_q == StRun);
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
    pool_full  = (free_count_q == PoolSize);
    // Widened by one bit so forward + NUM_FLOWS cannot wrap and alias a valid reverse.
    pair_ok    = ({1'b0, bus.rel_r_fea_addr} == ({1'b0, bus.rel_fea_addr} + RevOffset)) &&
                 ({1'b0, bus.rel_fea_addr} < RevOffset);
    rel_accept = in_run && bus.rel_v && pair_ok && !pool_full;
    alloc_fire = out_full_q && bus.alloc_ready;
    pop        = in_run && !fifo_empty && (!out_full_q || alloc_fire);
    wr_en      = (!in_run || rel_accept) && !fifo_full;
    wr_data    = in_run ? bus.rel_fea_addr[IdxW-1:0] : init_cnt_q;
  end

  flow_addr_pool_ram #(
    .Depth (NUM_FLOWS),
    .Width (IdxW)
  ) u_pool_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[IdxW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[IdxW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LastIdx) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        StRun: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      free_count_q   <= '0;
      out_full_q     <= 1'b0;
      out_idx_q      <= '0;
      err_overflow_q <= 1'b0;
      err_mismatch_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        out_full_q <= 1'b1;
        out_idx_q  <= rd_data;
      end else if (alloc_fire) begin
        out_full_q <= 1'b0;
      end
      if (wr_en && !alloc_fire) begin
        free_count_q <= free_count_q + 1'b1;
      end else if (!wr_en && alloc_fire) begin
        free_count_q <= free_count_q - 1'b1;
      end
      if (bus.rel_v) begin
        if (!in_run || !pair_ok) begin
          err_mismatch_q <= 1'b1;
        end
        if (in_run && pool_full) begin
          err_overflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.alloc_valid      = out_full_q;
  assign bus.alloc_fea_addr   = FEA_ADDR_W'(out_idx_q);
  assign bus.alloc_r_fea_addr = FEA_ADDR_W'(out_idx_q) + FEA_ADDR_W'(NUM_FLOWS);
  assign bus.init_done        = init_done_q;
  assign bus.free_count       = free_count_q;
  assign bus.err_overflow     = err_overflow_q;
  assign bus.err_mismatch     = err_mismatch_q;

endmodule

// File: tb/tb_flow_addr_free_list.sv
// Directed bench for flow_addr_free_list with an 8-pair pool.
module tb_flow_addr_free_list;
  import flow_addr_pkg::*;

  localparam int unsigned NFlows = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  flow_addr_free_list_if #(.NUM_FLOWS(NFlows)) bus ();

  flow_addr_free_list #(
    .NUM_FLOWS (NFlows)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle at the falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(bus.alloc_valid), 0);
    check({tag, "_fea"}, 32'(bus.alloc_fea_addr), 0);
    check({tag, "_rfea"}, 32'(bus.alloc_r_fea_addr), NFlows);
    check({tag, "_init_done"}, 32'(bus.init_done), 0);
    check({tag, "_free_count"}, 32'(bus.free_count), 0);
    check({tag, "_err_ovf"}, 32'(bus.err_overflow), 0);
    check({tag, "_err_mm"}, 32'(bus.err_mismatch), 0);
  endtask

  task automatic release_pair(input int f, input int r);
    bus.rel_v          = 1'b1;
    bus.rel_fea_addr   = 12'(f);
    bus.rel_r_fea_addr = 12'(r);
  endtask

  task automatic release_idle();
    bus.rel_v          = 1'b0;
    bus.rel_fea_addr   = '0;
    bus.rel_r_fea_addr = '0;
  endtask

  // Called right after rst_n rises at a falling edge, so the next rising edge is edge 1.
  task automatic init_phase(input bit inject_rel);
    for (int e = 1; e <= int'(NFlows); e++) begin
      if (inject_rel && e == 3) release_pair(1, 9);
      tick();
      release_idle();
      check($sformatf("init_free_count_e%0d", e), 32'(bus.free_count), 32'(e));
      check($sformatf("init_done_e%0d", e), 32'(bus.init_done), (e == int'(NFlows)) ? 1 : 0);
      check($sformatf("init_valid_e%0d", e), 32'(bus.alloc_valid), 0);
    end
    tick();
    check("first_valid", 32'(bus.alloc_valid), 1);
    check("first_fea", 32'(bus.alloc_fea_addr), 0);
    check("first_rfea", 32'(bus.alloc_r_fea_addr), NFlows);
    check("first_free_count", 32'(bus.free_count), NFlows);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.alloc_ready = 1'b0;
    release_idle();
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    init_phase(1'b0);

    // Outputs hold while the tracker stalls.
    for (int s = 0; s < 2; s++) begin
      tick();
      check("stall_valid", 32'(bus.alloc_valid), 1);
      check("stall_fea", 32'(bus.alloc_fea_addr), 0);
    end

    release_pair(2, 10);
    tick();
    release_idle();
    check("ovf_err", 32'(bus.err_overflow), 1);
    check("ovf_no_mm", 32'(bus.err_mismatch), 0);
    check("ovf_free_count", 32'(bus.free_count), NFlows);

    bus.alloc_ready = 1'b1;
    for (int j = 0; j < int'(NFlows); j++) begin
      check($sformatf("drain_valid_%0d", j), 32'(bus.alloc_valid), 1);
      check($sformatf("drain_fea_%0d", j), 32'(bus.alloc_fea_addr), 32'(j));
      check($sformatf("drain_rfea_%0d", j), 32'(bus.alloc_r_fea_addr), 32'(j + 8));
      tick();
      check($sformatf("drain_count_%0d", j), 32'(bus.free_count), 32'(7 - j));
    end
    bus.alloc_ready = 1'b0;
    check("drained_valid", 32'(bus.alloc_valid), 0);
    check("drained_count", 32'(bus.free_count), 0);

    release_pair(5, 13);
    tick();
    release_idle();
    check("rel5_count", 32'(bus.free_count), 1);
    check("rel5_valid_e1", 32'(bus.alloc_valid), 0);
    tick();
    check("rel5_valid_e2", 32'(bus.alloc_valid), 1);
    check("rel5_fea", 32'(bus.alloc_fea_addr), 5);
    check("rel5_rfea", 32'(bus.alloc_r_fea_addr), 13);

    release_pair(3, 12);
    tick();
    release_idle();
    check("mm_err", 32'(bus.err_mismatch), 1);
    check("mm_count", 32'(bus.free_count), 1);
    check("mm_ovf_sticky", 32'(bus.err_overflow), 1);
    check("mm_fea_hold", 32'(bus.alloc_fea_addr), 5);

    // Accepted release and allocation on the same edge.
    release_pair(6, 14);
    bus.alloc_ready = 1'b1;
    tick();
    release_idle();
    bus.alloc_ready = 1'b0;
    check("simul_count", 32'(bus.free_count), 1);
    check("simul_valid", 32'(bus.alloc_valid), 0);
    tick();
    check("simul_next_valid", 32'(bus.alloc_valid), 1);
    check("simul_next_fea", 32'(bus.alloc_fea_addr), 6);
    check("simul_next_rfea", 32'(bus.alloc_r_fea_addr), 14);

    rst_n = 1'b0;
    #1;
    check_reset_vals("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    init_phase(1'b0);
    bus.alloc_ready = 1'b1;
    repeat (3) tick();
    check("mid_fea", 32'(bus.alloc_fea_addr), 3);
    check("mid_count", 32'(bus.free_count), 5);

    rst_n = 1'b0;
    #1;
    check_reset_vals("rst2");
    bus.alloc_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    init_phase(1'b1);
    check("init_rel_mm", 32'(bus.err_mismatch), 1);
    check("init_rel_no_ovf", 32'(bus.err_overflow), 0);
    bus.alloc_ready = 1'b1;
    tick();
    bus.alloc_ready = 1'b0;
    check("restart_fea", 32'(bus.alloc_fea_addr), 1);
    check("restart_count", 32'(bus.free_count), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flow_addr_free_list.md
# flow_addr_free_list

Free-pair allocator for flow feature memory. It recycles the (forward, reverse) 12-bit feature-address pairs released by the inflight-address stage and hands free pairs to the flow tracker when a new flow is admitted. It sits directly downstream of the inflight-address stage: its release inputs are that stage's `free_fea_addr` / `free_r_fea_addr` / `free_fea_addr_v` outputs. After reset it self-initialises so that every pair starts out free.

## Interface
- `NUM_FLOWS`, 2048 — number of address pairs; power of two, 2..2048.
- `FEA_ADDR_W`, 12 — feature address width.
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `rel_v` in 1 — release strobe, one pair per cycle.
- `rel_fea_addr` in FEA_ADDR_W — forward address being freed.
- `rel_r_fea_addr` in FEA_ADDR_W — reverse address being freed.
- `alloc_valid` out 1 — a free pair is presented.
- `alloc_ready` in 1 — tracker takes the presented pair.
- `alloc_fea_addr` out FEA_ADDR_W — forward address of the presented pair.
- `alloc_r_fea_addr` out FEA_ADDR_W — reverse address, always `alloc_fea_addr + NUM_FLOWS`.
- `init_done` out 1 — high once initialisation completes.
- `free_count` out clog2(NUM_FLOWS)+1 — pairs currently owned by the block (RAM plus output register).
- `err_overflow` out 1 — sticky: a release arrived while `free_count == NUM_FLOWS`.
- `err_mismatch` out 1 — sticky: a release was invalid (malformed pair, forward address ≥ NUM_FLOWS, or arrival during INIT).

## Operation
- Storage is a circular FIFO of pair indices k (clog2(NUM_FLOWS) bits). The pair for index k is forward = k, reverse = k + NUM_FLOWS.
- State machine:
  - INIT: counter i runs 0..NUM_FLOWS-1 and writes index i at tail, one per cycle. On the last write, go to RUN and assert `init_done`.
  - RUN: normal operation; there is no exit except reset.
- Output register (1 entry):
  - It loads from the FIFO head when it is empty, or when it is being consumed (`alloc_valid & alloc_ready`), and the FIFO is non-empty.
  - `alloc_valid` equals output-register-full.
- Release in RUN with `rel_v`:
  - Accepted only if `rel_r_fea_addr == rel_fea_addr + NUM_FLOWS`, `rel_fea_addr < NUM_FLOWS`, and `free_count < NUM_FLOWS`.
  - Accepted: the index is written at tail and `free_count` increments.
  - Failed pair check: drop and set `err_mismatch`.
  - Full pool: drop and set `err_overflow`.
- `rel_v` during INIT: drop and set `err_mismatch`.
- Simultaneous accepted release and allocation in the same cycle: `free_count` is unchanged, and both pointers advance.
- Release into an empty FIFO while the output register is empty: the entry reaches the output register one edge later. There is no write-to-output bypass.
- No duplicate-release detection; the upstream stage guarantees each pair is freed once.
- Allocation order is strict FIFO: 0, 1, 2, … then released pairs in release order.
- Pointers are clog2(NUM_FLOWS)+1 bits with a wrap bit. Full = MSBs differ and the rest are equal; empty = all bits equal.

## Timing
- Reset values:
  - state = INIT, pointers = 0, output register empty.
  - `alloc_valid` = 0, `alloc_fea_addr` = 0, `alloc_r_fea_addr` = NUM_FLOWS.
  - `init_done` = 0, `free_count` = 0, `err_*` = 0.
- Reset mid-operation returns the block to INIT. All outstanding allocations are forgotten and the pool is rebuilt full.
- INIT write i occurs at the edge i+1 after reset release. `init_done` rises after edge NUM_FLOWS.
- `alloc_valid` first rises after edge NUM_FLOWS+1, presenting pair 0.
- `free_count` increments with each INIT write and with each accepted release, and decrements on each allocation handshake. It reads NUM_FLOWS when initialisation completes.
- Allocation handshake: the pair transfers on an edge with `alloc_valid & alloc_ready`. With a non-empty FIFO, the next pair is presented from the following cycle, giving a sustained 1 pair/cycle.
- Accepted release → visible in `free_count` after 1 edge. If the pool was fully drained, `alloc_valid` rises after 2 edges.
- `alloc_*` outputs are stable while `alloc_valid & !alloc_ready`.

## Structure
- Package `flow_addr_pkg`:
  - `FEA_ADDR_W` = 12, default `NUM_FLOWS` = 2048.
  - State enum {INIT, RUN}.
  - Pair-index typedef.
- Sub-module `flow_addr_pool_ram`: simple dual-port register array, NUM_FLOWS × clog2(NUM_FLOWS) bits, 1 synchronous write port, asynchronous read port, no reset on contents.
- Top level holds the FSM, pointers, output register, counters and error logic.

## Test plan
- Reset with NUM_FLOWS=8, `alloc_ready` held low:
  - `init_done` rises after edge 8 and `free_count` = 8.
  - `alloc_valid` rises after edge 9 with pair (0, 8).
- Hold `alloc_ready` high from init: pairs (0,8)…(7,15) on 8 consecutive edges, then `alloc_valid` = 0 and `free_count` = 0.
- Drain the pool, then release (5, 13):
  - `free_count` = 1 after 1 edge.
  - `alloc_valid` rises with (5, 13) after 2 edges.
- Release (3, 12) in RUN → dropped, `err_mismatch` = 1, `free_count` unchanged.
- Release (2, 10) with a full pool → `err_overflow` = 1, `free_count` stays 8.
- Pull `rst_n` low mid-stream after 3 allocations:
  - All outputs return to reset values.
  - INIT reruns, and allocation restarts at pair (0, 8).
